jt49_wr_sched: RTL

//  Write scheduler sitting in front of the jt49 PSG register bus. It lets two

---
 rtl/jt49_wr_sched.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/jt49_wr_sched.sv
// Two-requester write scheduler for the jt49 PSG register bus.
// Per-requester FIFOs drained round-robin, one write per cen edge plus a gap.
module jt49_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr,
  input  logic [11:0] din,
  input  logic        pop,
  output logic [11:0] dout,
  output logic        empty,
  output logic        full,
  output logic        ovf
);

  logic [11:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic          push;

  assign full  = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign push  = wr & ~full;
  assign dout  = mem[rptr];

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
      // full is judged on the registered count, so a same-edge pop
      // never makes room for a push
      if (wr & full) ovf <= 1'b1;
    end
  end

endmodule

module jt49_wr_sched #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       a_wr,
  input  logic [3:0] a_addr,
  input  logic [7:0] a_din,
  output logic       a_full,
  output logic       a_ovf,
  input  logic       b_wr,
  input  logic [3:0] b_addr,
  input  logic [7:0] b_din,
  output logic       b_full,
  output logic       b_ovf,
  output logic [3:0] psg_addr,
  output logic [7:0] psg_din,
  output logic       psg_cs_n,
  output logic       psg_wr_n,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    GAP
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        rr_last_b;
  logic        a_empty;
  logic        b_empty;
  logic [11:0] a_dout;
  logic [11:0] b_dout;
  logic        grant_a;
  logic        grant_b;
  logic        pop_a;
  logic        pop_b;
  logic        cs_clr;

  jt49_wr_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo_a (
    .clk   (clk),
    .rst   (rst),
    .wr    (a_wr),
    .din   ({a_addr, a_din}),
    .pop   (pop_a),
    .dout  (a_dout),
    .empty (a_empty),
    .full  (a_full),
    .ovf   (a_ovf)
  );

  jt49_wr_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo_b (
    .clk   (clk),
    .rst   (rst),
    .wr    (b_wr),
    .din   ({b_addr, b_din}),
    .pop   (pop_b),
    .dout  (b_dout),
    .empty (b_empty),
    .full  (b_full),
    .ovf   (b_ovf)
  );

  // with both pending, the side not served last wins
  assign grant_a = ~a_empty & (b_empty | rr_last_b);
  assign grant_b = ~b_empty & ~grant_a;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (grant_a | grant_b) state_nx = STROBE;
      STROBE:  if (cen) state_nx = GAP;
      GAP:     if (cen) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    pop_a  = (state == IDLE) & grant_a;
    pop_b  = (state == IDLE) & grant_b;
    cs_clr = (state == STROBE) & cen;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psg_addr  <= 4'd0;
      psg_din   <= 8'd0;
      psg_cs_n  <= 1'b1;
      rr_last_b <= 1'b1;
    end else begin
      unique case (1'b1)
        pop_a: begin
          {psg_addr, psg_din} <= a_dout;
          psg_cs_n  <= 1'b0;
          rr_last_b <= 1'b0;
        end
        pop_b: begin
          {psg_addr, psg_din} <= b_dout;
          psg_cs_n  <= 1'b0;
          rr_last_b <= 1'b1;
        end
        cs_clr:  psg_cs_n <= 1'b1;
        default: psg_cs_n <= psg_cs_n;
      endcase
    end
  end

  assign psg_wr_n = psg_cs_n;
  assign busy     = (state != IDLE) | ~a_empty | ~b_empty;

endmodule
